// File: rtl/spi_slave_responder.sv
// SPI device-side responder: oversamples sclk/cs_n/mosi on the system clock,
// captures each frame into rx_bits and shifts a preloaded response out on miso.
module spi_slave_responder #(
    parameter int MAX_BITS = 100
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cpol,
    input  logic                i_cpha,
    input  logic [MAX_BITS-1:0] i_resp_bits,
    input  logic [15:0]         i_resp_count,
    input  logic                i_sclk,
    input  logic                i_cs_n,
    input  logic                i_mosi,
    output logic                o_miso,
    output logic                o_miso_oe,
    output logic [MAX_BITS-1:0] o_rx_bits,
    output logic [15:0]         o_rx_count,
    output logic                o_frame_active,
    output logic                o_frame_done,
    output logic                o_overflow
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic                r_sclk_m, r_sclk_s, r_sclk_d;
    logic                r_cs_m, r_cs_s, r_cs_d;
    logic                r_mosi_m, r_mosi_s;
    logic [2:0]          r_vld;
    logic                r_armed;

    state_t              r_state, w_state_nxt;
    logic [MAX_BITS-1:0] r_tx_sh, w_tx_sh_nxt;
    logic [15:0]         r_tx_rem, w_tx_rem_nxt;
    logic                r_first, w_first_nxt;
    logic [MAX_BITS-1:0] r_rx_sh, w_rx_sh_nxt;
    logic [15:0]         r_cnt, w_cnt_nxt;
    logic                w_done;

    logic                r_miso, r_oe, r_active, r_done, r_ovf;
    logic [MAX_BITS-1:0] r_rx_bits;
    logic [15:0]         r_rx_count;

    logic                w_lead, w_trail, w_sample, w_shift;
    logic                w_cs_fall, w_cs_rise;
    logic [15:0]         w_rem_load;
    logic [MAX_BITS-1:0] w_tx_load;
    logic [MAX_BITS-1:0] w_rx_shifted;

    // Synchronisers plus one extra stage on sclk/cs_n for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_m <= 1'b0;
            r_sclk_s <= 1'b0;
            r_sclk_d <= 1'b0;
            r_cs_m   <= 1'b1;
            r_cs_s   <= 1'b1;
            r_cs_d   <= 1'b1;
            r_mosi_m <= 1'b0;
            r_mosi_s <= 1'b0;
            r_vld    <= 3'b000;
            r_armed  <= 1'b0;
        end else begin
            r_sclk_m <= i_sclk;
            r_sclk_s <= r_sclk_m;
            r_sclk_d <= r_sclk_s;
            r_cs_m   <= i_cs_n;
            r_cs_s   <= r_cs_m;
            r_cs_d   <= r_cs_s;
            r_mosi_m <= i_mosi;
            r_mosi_s <= r_mosi_m;
            r_vld    <= {r_vld[1:0], 1'b1};
            // A fall only counts once cs_n has really been seen high after reset,
            // so a master still holding cs_n low across reset cannot start a frame.
            r_armed  <= r_armed | (r_vld[2] & r_cs_d);
        end
    end

    always_comb begin
        w_lead    = (r_sclk_s != i_cpol) && (r_sclk_d == i_cpol);
        w_trail   = (r_sclk_s == i_cpol) && (r_sclk_d != i_cpol);
        w_sample  = i_cpha ? w_trail : w_lead;
        w_shift   = i_cpha ? w_lead  : w_trail;
        w_cs_fall = r_armed && !r_cs_s && r_cs_d;
        w_cs_rise = r_cs_s && !r_cs_d;
    end

    always_comb begin
        w_rem_load   = (32'(i_resp_count) > MAX_BITS) ? 16'(MAX_BITS) : i_resp_count;
        w_tx_load    = i_resp_bits << (MAX_BITS - int'(w_rem_load));
        w_rx_shifted = (r_rx_sh << 1) | MAX_BITS'(r_mosi_s);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tx_sh_nxt  = r_tx_sh;
        w_tx_rem_nxt = r_tx_rem;
        w_first_nxt  = r_first;
        w_rx_sh_nxt  = r_rx_sh;
        w_cnt_nxt    = r_cnt;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt  = S_ACTIVE;
                    w_tx_sh_nxt  = w_tx_load;
                    w_tx_rem_nxt = w_rem_load;
                    w_first_nxt  = 1'b1;
                    w_rx_sh_nxt  = '0;
                    w_cnt_nxt    = '0;
                end
            end
            S_ACTIVE: begin
                // cs_n rise takes priority over any coincident sample edge
                if (w_cs_rise) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end else begin
                    if (w_sample) begin
                        w_rx_sh_nxt = w_rx_shifted;
                        w_cnt_nxt   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                    end
                    if (w_shift) begin
                        if (i_cpha && r_first) begin
                            w_first_nxt = 1'b0;
                        end else if (r_tx_rem != 16'd0) begin
                            w_tx_sh_nxt  = r_tx_sh << 1;
                            w_tx_rem_nxt = r_tx_rem - 16'd1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_tx_sh    <= '0;
            r_tx_rem   <= '0;
            r_first    <= 1'b0;
            r_rx_sh    <= '0;
            r_cnt      <= '0;
            r_miso     <= 1'b0;
            r_oe       <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_rx_bits  <= '0;
            r_rx_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tx_sh  <= w_tx_sh_nxt;
            r_tx_rem <= w_tx_rem_nxt;
            r_first  <= w_first_nxt;
            r_rx_sh  <= w_rx_sh_nxt;
            r_cnt    <= w_cnt_nxt;
            r_miso   <= (w_state_nxt == S_ACTIVE) && (w_tx_rem_nxt != 16'd0) &&
                        w_tx_sh_nxt[MAX_BITS-1];
            r_oe     <= (w_state_nxt == S_ACTIVE);
            r_active <= (w_state_nxt == S_ACTIVE);
            r_done   <= w_done;
            if (w_done) begin
                r_rx_bits  <= r_rx_sh;
                r_rx_count <= r_cnt;
                r_ovf      <= (32'(r_cnt) > MAX_BITS);
            end
        end
    end

    assign o_miso         = r_miso;
    assign o_miso_oe      = r_oe;
    assign o_rx_bits      = r_rx_bits;
    assign o_rx_count     = r_rx_count;
    assign o_frame_active = r_active;
    assign o_frame_done   = r_done;
    assign o_overflow     = r_ovf;

endmodule
